// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one read per cycle to a synchronous
// instruction memory and buffers returned words in a small FIFO that feeds decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        PCS,
    input  logic [31:0] Jump,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    output logic        IFIDValid,
    output logic [31:0] IFIDInstr,
    output logic [31:0] IFIDPC,
    input  logic        IDReady
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic          pop;
    logic          push;
    logic [CW:0]   occupancy;

    // Decode handshake: a word transfers in any cycle where IFIDValid and IDReady are both
    // high and no redirect is active; otherwise the head (valid, instr, PC) is held unchanged.
    assign IFIDValid = (count != '0);
    assign IFIDInstr = instr_q[rd_ptr];
    assign IFIDPC    = pc_q[rd_ptr];

    assign pop  = IFIDValid & IDReady & ~PCS;
    assign push = inflight & ~PCS;

    // The in-flight word already owns a slot, so it counts against free space.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign IMemReq   = rst_n & ~PCS & (occupancy < (CW+1)'(DEPTH));
    assign IMemAddr  = fetch_pc;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (PCS) begin
            fetch_pc <= {Jump[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= IMemReq;
            if (IMemReq) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                instr_q[wr_ptr] <= IMemRdata;
                pc_q[wr_ptr]    <= inflight_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-level model checked every cycle, plus literal
// expectations per scenario and a second instance with a wrapping reset PC.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

    logic        CLK = 1'b0;
    logic        rst_n, rst2_n;
    logic        PCS;
    logic [31:0] Jump;
    logic        IDReady;
    logic        IMemReq, IMemReq2;
    logic [31:0] IMemAddr, IMemAddr2;
    logic [31:0] rdata = '0, rdata2 = '0;
    logic        IFIDValid, IFIDValid2;
    logic [31:0] IFIDInstr, IFIDInstr2, IFIDPC, IFIDPC2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(RPC_A), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .rst_n(rst_n), .PCS(PCS), .Jump(Jump),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(rdata),
        .IFIDValid(IFIDValid), .IFIDInstr(IFIDInstr), .IFIDPC(IFIDPC), .IDReady(IDReady)
    );

    fetch_unit #(.RESET_PC(RPC_B), .DEPTH(DEPTH)) dut2 (
        .CLK(CLK), .rst_n(rst2_n), .PCS(1'b0), .Jump(32'h0),
        .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemRdata(rdata2),
        .IFIDValid(IFIDValid2), .IFIDInstr(IFIDInstr2), .IFIDPC(IFIDPC2), .IDReady(1'b1)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a >> 2) ^ 32'h5A00_0000;
    endfunction

    // Synchronous memory: data for a request appears the following cycle.
    always @(posedge CLK) begin
        rdata  <= IMemReq  ? instr_of(IMemAddr)  : 32'hDEAD_BEEF;
        rdata2 <= IMemReq2 ? instr_of(IMemAddr2) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    // Model: buffered PCs in delivery order, one pending response, and the next fetch address.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = RPC_A;
    logic [31:0] m_pend_pc = '0;
    bit          m_pend = 1'b0;
    bit          m_valid, m_pop, m_req;
    int          m_occ;

    always @(negedge CLK) begin
        if (!rst_n) begin
            chk("rst_valid", {31'b0, IFIDValid}, 32'd0);
            chk("rst_req", {31'b0, IMemReq}, 32'd0);
            chk("rst_pc", IFIDPC, 32'd0);
            chk("rst_instr", IFIDInstr, 32'd0);
            exp_q.delete();
            m_pend = 1'b0;
            m_pc = RPC_A;
        end else begin
            m_valid = (exp_q.size() > 0);
            chk("m_valid", {31'b0, IFIDValid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("m_head_pc", IFIDPC, exp_q[0]);
                chk("m_head_instr", IFIDInstr, instr_of(exp_q[0]));
            end
            m_pop = m_valid && IDReady && !PCS;
            m_occ = exp_q.size() + (m_pend ? 1 : 0) - (m_pop ? 1 : 0);
            m_req = !PCS && (m_occ < DEPTH);
            chk("m_req", {31'b0, IMemReq}, {31'b0, m_req});
            if (m_req) chk("m_addr", IMemAddr, m_pc);
            if (PCS) begin
                exp_q.delete();
                m_pend = 1'b0;
                m_pc = {Jump[31:2], 2'b00};
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_pend) exp_q.push_back(m_pend_pc);
                m_pend = m_req;
                m_pend_pc = m_pc;
                if (m_req) m_pc = m_pc + 32'd4;
            end
        end
    end

    bit found;

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; PCS = 1'b0; Jump = '0; IDReady = 1'b1;
        repeat (3) cyc();

        // Streaming from reset with decode always ready.
        rst_n = 1'b1;
        neg(); chk("t1_c0_req", {31'b0, IMemReq}, 32'd1); chk("t1_c0_addr", IMemAddr, 32'h0);
        cyc(); neg(); chk("t1_c1_addr", IMemAddr, 32'h4); chk("t1_c1_valid", {31'b0, IFIDValid}, 32'd0);
        cyc(); neg(); chk("t1_c2_valid", {31'b0, IFIDValid}, 32'd1); chk("t1_c2_pc", IFIDPC, 32'h0);
        chk("t1_c2_instr", IFIDInstr, 32'h5A00_0000);
        cyc(); neg(); chk("t1_c3_pc", IFIDPC, 32'h4); chk("t1_c3_addr", IMemAddr, 32'hC);

        // Redirect from a steady stream at 0x40.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(); neg();
            if (IFIDValid && IFIDPC == 32'h40) found = 1'b1;
        end
        chk("t3_reach_40", {31'b0, found}, 32'd1);
        cyc(); PCS = 1'b1; Jump = 32'h100;
        neg(); chk("t3_t_req", {31'b0, IMemReq}, 32'd0); chk("t3_t_head", IFIDPC, 32'h44);
        cyc(); PCS = 1'b0;
        neg(); chk("t3_t1_valid", {31'b0, IFIDValid}, 32'd0); chk("t3_t1_addr", IMemAddr, 32'h100);
        chk("t3_t1_req", {31'b0, IMemReq}, 32'd1);
        cyc(); neg(); chk("t3_t2_valid", {31'b0, IFIDValid}, 32'd0);
        cyc(); neg(); chk("t3_t3_valid", {31'b0, IFIDValid}, 32'd1); chk("t3_t3_pc", IFIDPC, 32'h100);
        chk("t3_t3_instr", IFIDInstr, 32'h5A00_0040);
        cyc(); neg(); chk("t3_t4_pc", IFIDPC, 32'h104);

        // Decode stalled from reset: fill to DEPTH, hold, then drain and resume.
        cyc(); rst_n = 1'b0; IDReady = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        neg(); cyc(); neg(); cyc(); neg();
        chk("t2_c2_req", {31'b0, IMemReq}, 32'd0); chk("t2_c2_pc", IFIDPC, 32'h0);
        chk("t2_c2_valid", {31'b0, IFIDValid}, 32'd1);
        repeat (3) begin
            cyc(); neg();
            chk("t2_hold_pc", IFIDPC, 32'h0); chk("t2_hold_req", {31'b0, IMemReq}, 32'd0);
        end
        cyc(); IDReady = 1'b1;
        neg(); chk("t2_k_pc", IFIDPC, 32'h0); chk("t2_k_addr", IMemAddr, 32'h8);
        chk("t2_k_req", {31'b0, IMemReq}, 32'd1);
        cyc(); neg(); chk("t2_k1_pc", IFIDPC, 32'h4);
        cyc(); neg(); chk("t2_k2_pc", IFIDPC, 32'h8); chk("t2_k2_valid", {31'b0, IFIDValid}, 32'd1);

        // Reset pulse with a full FIFO.
        cyc(); IDReady = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b0;
        neg(); chk("t6_valid", {31'b0, IFIDValid}, 32'd0); chk("t6_req", {31'b0, IMemReq}, 32'd0);
        cyc(); IDReady = 1'b1;
        cyc(); rst_n = 1'b1;
        neg(); chk("t6_c0_addr", IMemAddr, 32'h0); chk("t6_c0_req", {31'b0, IMemReq}, 32'd1);
        cyc(); neg(); chk("t6_c1_valid", {31'b0, IFIDValid}, 32'd0);
        cyc(); neg(); chk("t6_c2_pc", IFIDPC, 32'h0); chk("t6_c2_instr", IFIDInstr, 32'h5A00_0000);

        // Redirect to an unaligned target while full and decode ready; then back-to-back.
        cyc(); IDReady = 1'b0;
        repeat (3) cyc();
        IDReady = 1'b1; PCS = 1'b1; Jump = 32'h0000_0203;
        neg(); chk("t4_t_req", {31'b0, IMemReq}, 32'd0);
        cyc(); PCS = 1'b0;
        neg(); chk("t4_t1_addr", IMemAddr, 32'h200);
        cyc(); neg(); chk("t4_t2_valid", {31'b0, IFIDValid}, 32'd0);
        cyc(); neg(); chk("t4_t3_pc", IFIDPC, 32'h200);
        cyc(); PCS = 1'b1; Jump = 32'h300;
        neg();
        cyc(); Jump = 32'h400;
        neg(); chk("t4_b2b_valid", {31'b0, IFIDValid}, 32'd0);
        cyc(); PCS = 1'b0;
        neg(); chk("t4_b2b_addr", IMemAddr, 32'h400);
        cyc(); neg(); chk("t4_b2b_v0", {31'b0, IFIDValid}, 32'd0);
        cyc(); neg(); chk("t4_b2b_pc0", IFIDPC, 32'h400);
        cyc(); neg(); chk("t4_b2b_pc1", IFIDPC, 32'h404);

        // Reset PC near the top of the address space: fetch wraps to zero.
        cyc(); rst2_n = 1'b1;
        neg(); chk("t5_c0_addr", IMemAddr2, 32'hFFFF_FFF8);
        cyc(); neg(); cyc(); neg();
        chk("t5_c2_pc", IFIDPC2, 32'hFFFF_FFF8); chk("t5_c2_addr", IMemAddr2, 32'h0);
        chk("t5_c2_instr", IFIDInstr2, 32'h65FF_FFFE);
        cyc(); neg(); chk("t5_c3_pc", IFIDPC2, 32'hFFFF_FFFC);
        cyc(); neg(); chk("t5_c4_pc", IFIDPC2, 32'h0); chk("t5_c4_instr", IFIDInstr2, 32'h5A00_0000);
        cyc(); neg(); chk("t5_c5_pc", IFIDPC2, 32'h4); chk("t5_c5_valid", {31'b0, IFIDValid2}, 32'd1);

        cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
